// File: rtl/jk_excite_if.sv
// Handshake and feedback bundle between a JK-bank controller and its driver.
// The master side supplies targets and the bank's q; the slave side drives J/K and reports the result.
interface jk_excite_if #(
   parameter int WIDTH = 4
) ();
   logic             tgt_valid;
   logic [WIDTH-1:0] tgt_data;
   logic             tgt_ready;
   logic [WIDTH-1:0] q_fb;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic             done;
   logic             err;

   modport master (
      output tgt_valid, tgt_data, q_fb,
      input  tgt_ready, j, k, done, err
   );

   modport slave (
      input  tgt_valid, tgt_data, q_fb,
      output tgt_ready, j, k, done, err
   );
endinterface

// File: rtl/jk_excite_driver.sv
// Drives a JK flip-flop bank toward a requested value, checks the result and re-drives up to MAX_RETRY times.
// Optional macro JK_EXCITE_TOGGLE_EN: encode changing bits as toggles (j=k=1) instead of set/reset.
module jk_excite_driver #(
   parameter int WIDTH     = 4,
   parameter int MAX_RETRY = 2
) (
   input logic        clk,
   input logic        rst,
   jk_excite_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
   localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] target_reg, target_next;
   logic [2:0]       retry_reg, retry_next;
   logic [WIDTH-1:0] j_reg, j_next;
   logic [WIDTH-1:0] k_reg, k_next;
   logic             done_reg, done_next;
   logic             err_reg, err_next;
   logic [WIDTH-1:0] exc_target;
   logic [WIDTH-1:0] exc_j;
   logic [WIDTH-1:0] exc_k;

   // At accept the incoming data is the goal; on a re-drive it is the latched target.
   assign exc_target = (state_reg == IDLE) ? bus.tgt_data : target_reg;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_exc
`ifdef JK_EXCITE_TOGGLE_EN
         assign exc_j[gi] = bus.q_fb[gi] ^ exc_target[gi];
         assign exc_k[gi] = bus.q_fb[gi] ^ exc_target[gi];
`else
         assign exc_j[gi] = ~bus.q_fb[gi] & exc_target[gi];
         assign exc_k[gi] = bus.q_fb[gi] & ~exc_target[gi];
`endif
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         target_reg <= '0;
         retry_reg  <= '0;
         j_reg      <= '0;
         k_reg      <= '0;
         done_reg   <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         target_reg <= target_next;
         retry_reg  <= retry_next;
         j_reg      <= j_next;
         k_reg      <= k_next;
         done_reg   <= done_next;
         err_reg    <= err_next;
      end
   end

   // j/k default to zero so they are only nonzero in the cycle following a (re)load.
   always_comb begin
      state_next  = state_reg;
      target_next = target_reg;
      retry_next  = retry_reg;
      j_next      = '0;
      k_next      = '0;
      done_next   = 1'b0;
      err_next    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.tgt_valid) begin
               target_next = bus.tgt_data;
               retry_next  = '0;
               j_next      = exc_j;
               k_next      = exc_k;
               state_next  = DRIVE;
            end
         end
         DRIVE: begin
            state_next = CHECK;
         end
         CHECK: begin
            if (bus.q_fb == target_reg) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end else if (retry_reg < RETRY_LIMIT) begin
               retry_next = retry_reg + 3'd1;
               j_next     = exc_j;
               k_next     = exc_k;
               state_next = DRIVE;
            end else begin
               err_next   = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.tgt_ready = (state_reg == IDLE);
   assign bus.j         = j_reg;
   assign bus.k         = k_reg;
   assign bus.done      = done_reg;
   assign bus.err       = err_reg;
endmodule

// File: tb/tb_jk_excite_driver.sv
// Randomized and directed bench for jk_excite_driver with a behavioural JK bank and a scoreboard monitor.
// Honors JK_EXCITE_TOGGLE_EN for the expected excitation encoding.
module tb_jk_excite_driver;
   localparam int W         = 4;
   localparam int MAX_RETRY = 2;
   localparam int DEPTH     = 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jk_excite_if #(.WIDTH(W)) bus ();

   jk_excite_driver #(.WIDTH(W), .MAX_RETRY(MAX_RETRY)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural JK bank; stuck bits override the bank output seen by the DUT.
   logic [W-1:0] bank_q     = '0;
   logic [W-1:0] stuck_mask = '0;
   logic [W-1:0] stuck_val  = '0;
   logic [W-1:0] load_val   = '0;
   logic         load_en    = 1'b1;

   assign bus.q_fb = (bank_q & ~stuck_mask) | (stuck_val & stuck_mask);

   function automatic logic [W-1:0] bank_next(input logic [W-1:0] q, input logic [W-1:0] jj,
                                              input logic [W-1:0] kk);
      logic [W-1:0] r;
      for (int b = 0; b < W; b++) begin
         case ({jj[b], kk[b]})
            2'b00:   r[b] = q[b];
            2'b01:   r[b] = 1'b0;
            2'b10:   r[b] = 1'b1;
            default: r[b] = ~q[b];
         endcase
      end
      return r;
   endfunction

   always @(posedge clk) begin
      if (load_en) bank_q <= load_val;
      else         bank_q <= bank_next(bus.q_fb, bus.j, bus.k);
   end

   // Reference: the required {j,k} to move q to t.
   function automatic logic [2*W-1:0] ref_exc(input logic [W-1:0] q, input logic [W-1:0] t);
`ifdef JK_EXCITE_TOGGLE_EN
      return {q ^ t, q ^ t};
`else
      return {~q & t, q & ~t};
`endif
   endfunction

   // Reference: outcome and cycles from accept-edge to the done/err cycle.
   function automatic void ref_run(input logic [W-1:0] t, input logic [W-1:0] sm,
                                   input logic [W-1:0] sv, output bit ok, output int lat);
      logic [W-1:0] q;
      ok  = 1'b0;
      lat = 2 + 2 * MAX_RETRY;
      for (int a = 0; a <= MAX_RETRY; a++) begin
         q = (t & ~sm) | (sv & sm);
         if (q == t) begin
            ok  = 1'b1;
            lat = 2 + 2 * a;
            return;
         end
      end
   endfunction

   // Scoreboard storage: stimulus writes entries and wr_ptr, monitor owns rd_ptr.
   int           r_e   [DEPTH];
   logic [W-1:0] r_q0  [DEPTH];
   logic [W-1:0] r_t   [DEPTH];
   logic [W-1:0] r_sm  [DEPTH];
   logic [W-1:0] r_sv  [DEPTH];
   bit           r_ok  [DEPTH];
   int           r_lat [DEPTH];
   int           wr_ptr = 0;
   int           rd_ptr = 0;

   int cyc        = 0;
   bit rst_edge   = 1'b1;
   bit finish_req = 1'b0;
   bit timeout    = 1'b0;

   int vectors    = 0;
   int miscompares = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
      rst_edge = rst;
   end

   task automatic check(input string name, input logic [2*W+2:0] act, input logic [2*W+2:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cyc=%0d {ready,done,err,j,k} actual=%b required=%b", name, cyc, act, exp);
      end
   endtask

   // Monitor: every cycle compare the DUT against the front scoreboard entry (or idle).
   initial begin
      logic [2*W+2:0] act;
      logic [2*W+2:0] exp;
      logic [W-1:0]   qa;
      int             off;
      forever begin
         @(negedge clk);
         if (finish_req) break;
         act = {bus.tgt_ready, bus.done, bus.err, bus.j, bus.k};
         if (rst_edge) begin
            check("reset", act, {3'b100, {(2*W){1'b0}}});
            rd_ptr = wr_ptr;
         end else if (rd_ptr != wr_ptr && cyc >= r_e[rd_ptr % DEPTH]) begin
            off = cyc - r_e[rd_ptr % DEPTH];
            if (off < r_lat[rd_ptr % DEPTH]) begin
               qa = (off == 0) ? r_q0[rd_ptr % DEPTH]
                  : ((r_t[rd_ptr % DEPTH] & ~r_sm[rd_ptr % DEPTH]) |
                     (r_sv[rd_ptr % DEPTH] & r_sm[rd_ptr % DEPTH]));
               exp = (off % 2 == 0) ? {3'b000, ref_exc(qa, r_t[rd_ptr % DEPTH])}
                                    : {3'b000, {(2*W){1'b0}}};
               check((off % 2 == 0) ? "drive" : "check", act, exp);
            end else begin
               exp = {1'b1, r_ok[rd_ptr % DEPTH], ~r_ok[rd_ptr % DEPTH], {(2*W){1'b0}}};
               check("result", act, exp);
               rd_ptr++;
            end
         end else begin
            check("idle", act, {3'b100, {(2*W){1'b0}}});
         end
      end
      vectors++;
      if (timeout || rd_ptr != wr_ptr) begin
         miscompares++;
         $display("FAIL drain timeout=%0d pending actual=%0d required=0", timeout, wr_ptr - rd_ptr);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   // Stimulus helpers, all called at a negedge.
   task automatic wait_idle();
      for (int i = 0; i < 50; i++) begin
         if (bus.tgt_ready) return;
         @(negedge clk);
      end
      $display("FAIL wait_idle actual=busy required=ready");
      timeout = 1'b1;
   endtask

   task automatic push(input logic [W-1:0] t, input logic [W-1:0] sm, input logic [W-1:0] sv);
      bit ok;
      int lat;
      stuck_mask = sm;
      stuck_val  = sv;
      ref_run(t, sm, sv, ok, lat);
      r_e  [wr_ptr % DEPTH] = cyc + 1;
      r_q0 [wr_ptr % DEPTH] = (bank_q & ~sm) | (sv & sm);
      r_t  [wr_ptr % DEPTH] = t;
      r_sm [wr_ptr % DEPTH] = sm;
      r_sv [wr_ptr % DEPTH] = sv;
      r_ok [wr_ptr % DEPTH] = ok;
      r_lat[wr_ptr % DEPTH] = lat;
      bus.tgt_valid = 1'b1;
      bus.tgt_data  = t;
      wr_ptr++;
   endtask

   task automatic load_q(input logic [W-1:0] q);
      bus.tgt_valid = 1'b0;
      load_en  = 1'b1;
      load_val = q;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic directed(input logic [W-1:0] q, input logic [W-1:0] t,
                           input logic [W-1:0] sm, input logic [W-1:0] sv);
      wait_idle();
      stuck_mask = '0;
      load_q(q);
      push(t, sm, sv);
      @(negedge clk);
      bus.tgt_valid = 1'b0;
   endtask

   initial begin
      bus.tgt_valid = 1'b0;
      bus.tgt_data  = '0;
      repeat (3) @(negedge clk);
      rst     = 1'b0;
      load_en = 1'b0;
      @(negedge clk);

`ifdef JK_EXCITE_TOGGLE_EN
      directed(4'b1100, 4'b0110, 4'b0000, 4'b0000);
`else
      directed(4'b0000, 4'b1010, 4'b0000, 4'b0000);
`endif
      directed(4'b0000, 4'b0001, 4'b0001, 4'b0000);
      directed(4'b0101, 4'b0101, 4'b0000, 4'b0000);

      // Reset during CHECK, with a competing request on the reset edge.
      wait_idle();
      stuck_mask = '0;
      load_q(4'b0000);
      push(4'b1010, 4'b0000, 4'b0000);
      @(negedge clk);
      bus.tgt_valid = 1'b0;
      @(negedge clk);
      rst           = 1'b1;
      bus.tgt_valid = 1'b1;
      bus.tgt_data  = 4'b0111;
      @(negedge clk);
      rst           = 1'b0;
      bus.tgt_valid = 1'b0;
      directed(4'b0000, 4'b1010, 4'b0000, 4'b0000);

      // Busy-ignore then back-to-back accept in the done cycle.
      wait_idle();
      stuck_mask = '0;
      load_q(4'b0000);
      push(4'b0011, 4'b0000, 4'b0000);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.tgt_ready) begin
            push(4'($urandom), 4'b0000, 4'b0000);
            break;
         end
         bus.tgt_valid = 1'b1;
         bus.tgt_data  = 4'($urandom);
      end
      @(negedge clk);
      bus.tgt_valid = 1'b0;

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         int r;
         load_en = 1'b0;
         r = int'($urandom_range(0, 9));
         if (bus.tgt_ready && r == 0) begin
            bus.tgt_valid = 1'b0;
            load_en  = 1'b1;
            load_val = 4'($urandom);
         end else if (r < 6 && bus.tgt_ready) begin
            if ($urandom_range(0, 3) == 0) push(4'($urandom), 4'($urandom), 4'($urandom));
            else                           push(4'($urandom), 4'b0000, 4'b0000);
         end else begin
            bus.tgt_valid = (r < 6);
            bus.tgt_data  = 4'($urandom);
         end
         @(negedge clk);
      end
      load_en       = 1'b0;
      bus.tgt_valid = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      finish_req = 1'b1;
   end
endmodule
